// File: rtl/core_bus_pkg.sv
// core_bus_pkg: shared encodings for the core memory port arbiter
package core_bus_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/core_mem_port_arb_if.sv
// core_mem_port_arb_if: requester-side handshake and AHB-style bus pins of the arbiter
interface core_mem_port_arb_if #(
    parameter int CH_NUM = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [CH_NUM-1:0]        req_rd_en;
    logic [CH_NUM-1:0]        req_wr_en;
    logic [CH_NUM*ADDR_W-1:0] req_addr;
    logic [CH_NUM*DATA_W-1:0] req_wr_data;
    logic [CH_NUM*2-1:0]      req_size;
    logic [CH_NUM-1:0]        req_ack;
    logic [CH_NUM-1:0]        rsp_vld;
    logic                     rsp_err;
    logic [DATA_W-1:0]        rsp_data;
    logic                     ahb_rd_en;
    logic                     ahb_wr_en;
    logic [ADDR_W-1:0]        ahb_addr;
    logic [DATA_W-1:0]        ahb_wr_data;
    logic [1:0]               ahb_size;
    logic [DATA_W-1:0]        ahb_rd_data;
    logic                     ahb_rd_vld;
    logic                     ahb_busy;
    modport slave (
        input  req_rd_en, req_wr_en, req_addr, req_wr_data, req_size,
        input  ahb_rd_data, ahb_rd_vld, ahb_busy,
        output req_ack, rsp_vld, rsp_err, rsp_data,
        output ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size
    );
    modport master (
        output req_rd_en, req_wr_en, req_addr, req_wr_data, req_size,
        output ahb_rd_data, ahb_rd_vld, ahb_busy,
        input  req_ack, rsp_vld, rsp_err, rsp_data,
        input  ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant, round-robin from a registered pointer or fixed priority from ch0
module rr_arbiter
    import core_bus_pkg::*;
#(
    parameter int CH_NUM = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH_NUM-1:0]         req,
    input  logic                      mode,
    input  logic                      upd,
    output logic [CH_NUM-1:0]         gnt,
    output logic [idx_w(CH_NUM)-1:0]  gnt_idx
);
    localparam int IW = idx_w(CH_NUM);
    logic [IW-1:0] ptr;
    logic found;
    int j;
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < CH_NUM; i++) begin
            j = (mode == PRIO_FIXED ? 0 : int'(ptr)) + i;
            j = j >= CH_NUM ? j - CH_NUM : j;
            if (!found && req[j]) begin
                found = 1'b1;
                gnt[j] = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (upd && mode == PRIO_RR) ptr <= int'(gnt_idx) == CH_NUM - 1 ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/core_mem_port_arb.sv
// core_mem_port_arb: shares one AHB-style load/store port between CH_NUM requesters
module core_mem_port_arb
    import core_bus_pkg::*;
#(
    parameter int CH_NUM    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    core_mem_port_arb_if.slave  bus
);
    localparam int IW = idx_w(CH_NUM);
    localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_nx;
    logic [CH_NUM-1:0] act, gnt, ack_nx, vld_nx;
    logic [IW-1:0] gnt_idx, cur;
    logic [TW-1:0] cnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [1:0] w_size;
    logic take, ill, wr_sel, issue, rd_done, wr_done, to_hit, err_nx;
    assign act     = (bus.req_rd_en | bus.req_wr_en) & ~bus.req_ack;
    assign take    = state == IDLE && |act && !bus.ahb_busy;
    assign w_addr  = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign w_data  = bus.req_wr_data[gnt_idx*DATA_W +: DATA_W];
    assign w_size  = bus.req_size[gnt_idx*2 +: 2];
    assign ill     = w_size == SZ_ILL;
    assign wr_sel  = bus.req_wr_en[gnt_idx];
    assign issue   = take && !ill;
    assign rd_done = state == RD_WAIT && !bus.ahb_rd_en && bus.ahb_rd_vld;
    assign wr_done = state == WR_WAIT && !bus.ahb_wr_en && !bus.ahb_busy;
    assign to_hit  = TIMEOUT != 0 && state != IDLE && cnt == TW'(TIMEOUT);
    rr_arbiter #(.CH_NUM(CH_NUM)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (act),
        .mode    (PRIO_MODE == 1 ? PRIO_FIXED : PRIO_RR),
        .upd     (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );
    always_comb begin
        state_nx = state;
        ack_nx = take ? gnt : '0;
        vld_nx = '0;
        err_nx = 1'b0;
        if (issue) state_nx = wr_sel ? WR_WAIT : RD_WAIT;
        else if (take) begin
            vld_nx = gnt;
            err_nx = 1'b1;
        end else if (rd_done || wr_done || to_hit) begin
            state_nx = IDLE;
            vld_nx = CH_NUM'(1) << cur;
            err_nx = !rd_done && !wr_done;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.req_ack     <= '0;
            bus.rsp_vld     <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_data    <= '0;
            bus.ahb_rd_en   <= 1'b0;
            bus.ahb_wr_en   <= 1'b0;
            bus.ahb_addr    <= '0;
            bus.ahb_wr_data <= '0;
            bus.ahb_size    <= '0;
            cur             <= '0;
            cnt             <= '0;
        end else begin
            bus.req_ack   <= ack_nx;
            bus.rsp_vld   <= vld_nx;
            bus.rsp_err   <= err_nx;
            bus.ahb_rd_en <= issue && !wr_sel;
            bus.ahb_wr_en <= issue && wr_sel;
            cnt <= issue ? '0 : (TIMEOUT != 0 && state != IDLE) ? cnt + 1'b1 : cnt;
            if (issue) begin
                bus.ahb_addr    <= w_addr;
                bus.ahb_wr_data <= w_data;
                bus.ahb_size    <= w_size;
                cur             <= gnt_idx;
            end
            if (rd_done) bus.rsp_data <= bus.ahb_rd_data;
        end
    end
endmodule
